// File: rtl/slice_serial_logic_unit_if.sv
// rtl/slice_serial_logic_unit_if.sv - start/done handshake and operand/result bus for the slice-serial logic unit
interface slice_serial_logic_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             zero;

  modport master (output start, op, a, b, input busy, done, y, zero);
  modport slave  (input start, op, a, b, output busy, done, y, zero);
endinterface

// File: rtl/slice_serial_logic_unit.sv
// rtl/slice_serial_logic_unit.sv - multi-cycle AND/OR/XOR/NOR unit, one SLICE-bit slice per clock, LSB first
module slice_serial_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  slice_serial_logic_unit_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_final;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;
  logic             accept;
  logic             last;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] f_sl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.start;
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        accept     = bus.start;
        state_next = bus.start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign last = (idx == IDXW'(NSLICE - 1));
  assign a_sl = a_q[int'(idx) * SLICE +: SLICE];
  assign b_sl = b_q[int'(idx) * SLICE +: SLICE];

  always_comb begin
    f_sl = '0;
    case (op_q)
      2'b00:   f_sl = a_sl & b_sl;
      2'b01:   f_sl = a_sl | b_sl;
      2'b10:   f_sl = a_sl ^ b_sl;
      default: f_sl = ~(a_sl | b_sl);
    endcase
  end

  // Final accumulator value must include the slice being written on this edge.
  always_comb begin
    acc_final = acc;
    acc_final[int'(idx) * SLICE +: SLICE] = f_sl;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      acc    <= '0;
      idx    <= '0;
      y_q    <= '0;
      zero_q <= 1'b1;
    end else if (accept) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      op_q <= bus.op;
      idx  <= '0;
    end else if (state == RUN) begin
      acc <= acc_final;
      if (last) begin
        y_q    <= acc_final;
        zero_q <= (acc_final == '0);
      end else begin
        idx <= idx + IDXW'(1);
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.y    = y_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_slice_serial_logic_unit.sv
// tb/tb_slice_serial_logic_unit.sv - directed and swept checks of slice_serial_logic_unit
module tb_slice_serial_logic_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  slice_serial_logic_unit_if #(.WIDTH(32)) i32 ();
  slice_serial_logic_unit_if #(.WIDTH(8))  i8  ();
  slice_serial_logic_unit_if #(.WIDTH(16)) i16 ();
  slice_serial_logic_unit_if #(.WIDTH(64)) i64 ();

  slice_serial_logic_unit #(.WIDTH(32), .SLICE(4))  dut32 (.clk(clk), .reset(reset), .bus(i32));
  slice_serial_logic_unit #(.WIDTH(8),  .SLICE(8))  dut8  (.clk(clk), .reset(reset), .bus(i8));
  slice_serial_logic_unit #(.WIDTH(16), .SLICE(1))  dut16 (.clk(clk), .reset(reset), .bus(i16));
  slice_serial_logic_unit #(.WIDTH(64), .SLICE(16)) dut64 (.clk(clk), .reset(reset), .bus(i64));

  logic [2:0]  sw_done;
  logic [2:0]  sw_zero;
  logic [63:0] sw_y [3];
  assign sw_done = {i64.done, i16.done, i8.done};
  assign sw_zero = {i64.zero, i16.zero, i8.zero};
  assign sw_y[0] = {56'd0, i8.y};
  assign sw_y[1] = {48'd0, i16.y};
  assign sw_y[2] = i64.y;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_logic(input logic [63:0] x, input logic [63:0] z, input logic [1:0] o);
    case (o)
      2'b00:   return x & z;
      2'b01:   return x | z;
      2'b10:   return x ^ z;
      default: return ~(x | z);
    endcase
  endfunction

  // Called at a negedge; returns cycles from the accepting edge to done.
  task automatic run32(input logic [31:0] ta, input logic [31:0] tb_v, input logic [1:0] top,
                       output int lat, output int busy_n);
    i32.a = ta; i32.b = tb_v; i32.op = top; i32.start = 1'b1;
    @(negedge clk);
    i32.start = 1'b0;
    lat = 0; busy_n = 0;
    while (!i32.done && lat < 40) begin
      if (i32.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drive_sw(input int which, input logic [63:0] ta, input logic [63:0] tb_v,
                          input logic [1:0] top, input logic st);
    case (which)
      0:       begin i8.a  = ta[7:0];  i8.b  = tb_v[7:0];  i8.op  = top; i8.start  = st; end
      1:       begin i16.a = ta[15:0]; i16.b = tb_v[15:0]; i16.op = top; i16.start = st; end
      default: begin i64.a = ta;       i64.b = tb_v;       i64.op = top; i64.start = st; end
    endcase
  endtask

  task automatic sweep(input int which, input int w, input int ns);
    logic [63:0] mask, ra, rb, exp;
    logic [1:0]  rop;
    int          lat;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    for (int n = 0; n < 1000; n++) begin
      ra  = {$urandom, $urandom} & mask;
      rb  = {$urandom, $urandom} & mask;
      rop = 2'($urandom_range(0, 3));
      if (n % 100 == 0) begin rb = '0; rop = 2'b00; end
      exp = ref_logic(ra, rb, rop) & mask;
      drive_sw(which, ra, rb, rop, 1'b1);
      @(negedge clk);
      drive_sw(which, ra, rb, rop, 1'b0);
      lat = 0;
      while (!sw_done[which] && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      check("sweep_lat", 64'(lat), 64'(ns));
      check("sweep_y", sw_y[which], exp);
      check("sweep_zero", 64'(sw_zero[which]), 64'(exp == 64'd0));
    end
  endtask

  initial begin
    int          lat, busy_n, dones;
    logic [31:0] y_hold;
    logic        z_hold;

    reset = 1'b1;
    i32.start = 0; i32.op = 0; i32.a = 0; i32.b = 0;
    i8.start  = 0; i8.op  = 0; i8.a  = 0; i8.b  = 0;
    i16.start = 0; i16.op = 0; i16.a = 0; i16.b = 0;
    i64.start = 0; i64.op = 0; i64.a = 0; i64.b = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(i32.busy), 64'd0);
    check("rst_done", 64'(i32.done), 64'd0);
    check("rst_y", 64'(i32.y), 64'd0);
    check("rst_zero", 64'(i32.zero), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    run32(32'hF0F0_F0F0, 32'hFF00_FF00, 2'b00, lat, busy_n);
    check("and_lat", 64'(lat), 64'd8);
    check("and_busy_cycles", 64'(busy_n), 64'd8);
    check("and_y", 64'(i32.y), 64'hF000_F000);
    check("and_zero", 64'(i32.zero), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(i32.done), 64'd0);

    run32(32'h1234_5678, 32'h0F0F_0F0F, 2'b01, lat, busy_n);
    check("or_y", 64'(i32.y), 64'h1F3F_5F7F);
    run32(32'h1234_5678, 32'h0F0F_0F0F, 2'b10, lat, busy_n);
    check("xor_y", 64'(i32.y), 64'h1D3B_5977);
    run32(32'h1234_5678, 32'h0F0F_0F0F, 2'b11, lat, busy_n);
    check("nor_y", 64'(i32.y), 64'hE0C0_A080);
    check("nor_zero", 64'(i32.zero), 64'd0);
    run32(32'h1234_5678, 32'h0000_0000, 2'b00, lat, busy_n);
    check("and0_y", 64'(i32.y), 64'd0);
    check("and0_zero", 64'(i32.zero), 64'd1);

    // Start held high, operands scrambled while busy, back-to-back on DONE.
    @(negedge clk);
    i32.a = 32'hCAFE_BABE; i32.b = 32'h1234_5678; i32.op = 2'b10; i32.start = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!i32.done && lat < 40) begin
      i32.a = $urandom; i32.b = $urandom; i32.op = 2'($urandom_range(0, 3));
      @(negedge clk);
      lat++;
    end
    check("held_first_y", 64'(i32.y), 64'hD8CA_ECC6);
    i32.a = 32'hFFFF_0000; i32.b = 32'h0F0F_0F0F; i32.op = 2'b01;
    @(negedge clk);
    i32.start = 1'b0;
    lat = 1;
    while (!i32.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_spacing", 64'(lat), 64'd9);
    check("b2b_y", 64'(i32.y), 64'hFFFF_0F0F);

    // Asynchronous reset after slice 3 has been written.
    @(negedge clk);
    i32.a = 32'hAAAA_AAAA; i32.b = 32'h5555_5555; i32.op = 2'b01; i32.start = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    i32.start = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 64'(i32.busy), 64'd0);
    check("arst_done", 64'(i32.done), 64'd0);
    check("arst_y", 64'(i32.y), 64'd0);
    check("arst_zero", 64'(i32.zero), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (i32.done) dones++;
    end
    check("arst_no_done", 64'(dones), 64'd0);
    run32(32'h0000_0000, 32'h0000_0000, 2'b11, lat, busy_n);
    check("post_rst_y", 64'(i32.y), 64'hFFFF_FFFF);
    check("post_rst_lat", 64'(lat), 64'd8);

    // Hold: inputs wiggle without start.
    y_hold = i32.y;
    z_hold = i32.zero;
    for (int k = 0; k < 20; k++) begin
      i32.a = $urandom; i32.b = $urandom; i32.op = 2'(k);
      @(negedge clk);
      check("hold_y", 64'(i32.y), 64'hFFFF_FFFF);
      check("hold_zero", 64'(z_hold), 64'(i32.zero));
      check("hold_done", 64'(i32.done), 64'd0);
    end
    check("hold_y_const", 64'(i32.y), 64'(y_hold));

    sweep(0, 8, 1);
    sweep(1, 16, 16);
    sweep(2, 64, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
